riscv_biu_tcm_responder: RTL and testbench

BIU-side target that answers the memory-side BIU protocol driven by the data-memory controller and data cache (stb/stb_ack, d_ack, ack/err, adro, tags). It is backed by a local word-organised RAM and serves as a tightly-coupled data memory and as a bench responder. It supports single transfers and fixed-length INCR/WRAP bursts, with a configurable wait-state count per beat. Out-of-window, misaligned and unsupported accesses return err.

---
 rtl/biu_constants_pkg.sv | 54 +++++
 rtl/riscv_biu_beatgen.sv | 58 +++++
 rtl/riscv_biu_tcm_responder.sv | 182 ++++++++++++++++++
 tb/tb_riscv_biu_tcm_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// BIU protocol types shared by the data-memory controller, cache and TCM responder,
// plus the beat-count and byte-enable helpers used when decoding a request.
package biu_constants_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'b000,
    HWORD = 3'b001,
    WORD  = 3'b010,
    DWORD = 3'b011
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } biu_type_t;

  typedef logic [2:0] biu_prot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2,
    ST_ERR  = 2'd3
  } tcm_state_t;

  // Undefined-length INCR reports 0 beats; the responder rejects it.
  function automatic logic [4:0] biu_type2beats(input biu_type_t t);
    case (t)
      SINGLE:         return 5'd1;
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

  // Byte enables for a 64-bit lane group; 32-bit users pass adr[2]=0 and keep [3:0].
  function automatic logic [7:0] biu_size2be(input biu_size_t s, input logic [2:0] adr);
    case (s)
      BYTE:    return 8'h01 << adr;
      HWORD:   return 8'h03 << adr;
      WORD:    return 8'h0F << adr;
      DWORD:   return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/riscv_biu_beatgen.sv
// Beat sequencer: current/next beat address for INCR and WRAP bursts and a
// remaining-beat counter that flags the final beat.
module riscv_biu_beatgen
  import biu_constants_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            adv_i,
  input  logic [PLEN-1:0] adr_i,
  input  biu_type_t       type_i,
  output logic [PLEN-1:0] adr_o,
  output logic [PLEN-1:0] nxt_adr_o,
  output logic            last_o
);
  localparam int BPW = XLEN / 8;

  logic [PLEN-1:0] adr_q, inc, mask;
  logic [3:0]      cnt_q;
  logic [4:0]      nb;
  biu_type_t       type_q;

  always_comb begin
    nb   = biu_type2beats(type_i) - 5'd1;
    inc  = adr_q + PLEN'(BPW);
    mask = '0;
    case (type_q)
      WRAP4:   mask = PLEN'(4 * BPW - 1);
      WRAP8:   mask = PLEN'(8 * BPW - 1);
      WRAP16:  mask = PLEN'(16 * BPW - 1);
      default: mask = '0;
    endcase
    // WRAP keeps the upper bits of the aligned block and lets only the offset roll over
    nxt_adr_o = (mask == '0) ? inc : ((adr_q & ~mask) | (inc & mask));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q  <= '0;
      cnt_q  <= '0;
      type_q <= SINGLE;
    end else if (load_i) begin
      adr_q  <= adr_i;
      cnt_q  <= nb[3:0];
      type_q <= type_i;
    end else if (adv_i) begin
      adr_q  <= nxt_adr_o;
      cnt_q  <= cnt_q - 4'd1;
    end
  end

  assign adr_o  = adr_q;
  assign last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/riscv_biu_tcm_responder.sv
// BIU target backed by a word-organised RAM: single and fixed-length INCR/WRAP
// bursts with a fixed wait-state count per beat; bad requests answer with err.
module riscv_biu_tcm_responder
  import biu_constants_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              PLEN        = 32,
  parameter int              BIUTAG_SIZE = 2,
  parameter int              DEPTH       = 1024,
  parameter longint unsigned BASE        = 0,
  parameter int              WAIT_STATES = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   biu_stb_i,
  output logic                   biu_stb_ack_o,
  output logic                   biu_d_ack_o,
  input  logic [PLEN-1:0]        biu_adri_i,
  output logic [PLEN-1:0]        biu_adro_o,
  input  biu_size_t              biu_size_i,
  input  biu_type_t              biu_type_i,
  input  logic                   biu_we_i,
  input  logic                   biu_lock_i,
  input  biu_prot_t              biu_prot_i,
  input  logic [XLEN-1:0]        biu_d_i,
  output logic [XLEN-1:0]        biu_q_o,
  output logic                   biu_ack_o,
  output logic                   biu_err_o,
  input  logic [BIUTAG_SIZE-1:0] biu_tagi_i,
  output logic [BIUTAG_SIZE-1:0] biu_tago_o
);
  localparam int              BPW    = XLEN / 8;
  localparam int              LB     = $clog2(BPW);
  localparam int              AW     = $clog2(DEPTH);
  localparam longint unsigned WIN    = longint'(DEPTH) * longint'(BPW);
  localparam logic [PLEN-1:0] BASE_P = PLEN'(BASE);
  localparam biu_size_t       XSIZE  = (XLEN == 64) ? DWORD : WORD;
  localparam logic [3:0]      WS_LD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // Offset wraps to a huge value below BASE, so one compare covers both edges
  function automatic logic in_win(input logic [PLEN-1:0] a);
    logic [63:0] off;
    off = 64'(a) - BASE;
    return off < WIN;
  endfunction

  tcm_state_t state_q, state_d;

  logic                   load, acc_err, aligned, last;
  logic                   beat_ok, beat_err, rd_ack, wr_en;
  logic                   we_q;
  biu_size_t              size_q;
  logic [BIUTAG_SIZE-1:0] tag_q;
  logic [3:0]             wcnt_q;
  logic [PLEN-1:0]        cur_adr, nxt_adr, rd_adr, rd_off, wr_off;
  logic [AW-1:0]          rd_idx, wr_idx;
  logic [2:0]             lane_off;
  logic [7:0]             be8;
  logic [BPW-1:0]         be;
  logic [XLEN-1:0]        mem [DEPTH];
  logic [XLEN-1:0]        ram_q, hold_q;
  logic                   unused_ok;

  assign load = (state_q == ST_IDLE) && biu_stb_i;

  always_comb begin
    aligned = 1'b0;
    case (biu_size_i)
      BYTE:    aligned = 1'b1;
      HWORD:   aligned = ~biu_adri_i[0];
      WORD:    aligned = (biu_adri_i[1:0] == 2'b00);
      DWORD:   aligned = (XLEN == 64) && (biu_adri_i[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
    acc_err = !in_win(biu_adri_i) || !aligned
           || ((biu_type_i != SINGLE) && (biu_size_i != XSIZE))
           || (biu_type_i == INCR);
  end

  riscv_biu_beatgen #(.XLEN(XLEN), .PLEN(PLEN)) u_beatgen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .adv_i     (beat_ok),
    .adr_i     (biu_adri_i),
    .type_i    (biu_type_i),
    .adr_o     (cur_adr),
    .nxt_adr_o (nxt_adr),
    .last_o    (last)
  );

  // An INCR burst running off the window top answers that beat with err
  assign beat_ok  = (state_q == ST_BEAT) && in_win(cur_adr);
  assign beat_err = (state_q == ST_BEAT) && !in_win(cur_adr);
  assign rd_ack   = beat_ok && !we_q;
  assign wr_en    = beat_ok && we_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (biu_stb_i) state_d = acc_err ? ST_ERR
                                      : ((WAIT_STATES == 0) ? ST_BEAT : ST_WAIT);
      ST_WAIT: if (wcnt_q == 4'd0) state_d = ST_BEAT;
      ST_BEAT: if (beat_err || last) state_d = ST_IDLE;
               else state_d = (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      size_q <= BYTE;
      tag_q  <= '0;
      wcnt_q <= '0;
      hold_q <= '0;
    end else begin
      if (load) begin
        we_q   <= biu_we_i;
        size_q <= biu_size_i;
        tag_q  <= biu_tagi_i;
      end
      if (load || (state_q == ST_BEAT)) wcnt_q <= WS_LD;
      else if (state_q == ST_WAIT)      wcnt_q <= wcnt_q - 4'd1;
      if (rd_ack) hold_q <= ram_q;
    end
  end

  // Synchronous RAM: a BEAT cycle already fetches the following beat's word
  always_comb begin
    case (state_q)
      ST_IDLE: rd_adr = biu_adri_i;
      ST_BEAT: rd_adr = nxt_adr;
      default: rd_adr = cur_adr;
    endcase
    rd_off   = rd_adr - BASE_P;
    wr_off   = cur_adr - BASE_P;
    rd_idx   = rd_off[LB +: AW];
    wr_idx   = wr_off[LB +: AW];
    lane_off = '0;
    lane_off[LB-1:0] = cur_adr[LB-1:0];
    be8      = biu_size2be(size_q, lane_off);
    be       = be8[BPW-1:0];
  end

  always_ff @(posedge clk_i) begin
    ram_q <= mem[rd_idx];
    if (wr_en) begin
      for (int i = 0; i < BPW; i++)
        if (be[i]) mem[wr_idx][8*i +: 8] <= biu_d_i[8*i +: 8];
    end
  end

  always_comb begin
    biu_stb_ack_o = (state_q == ST_IDLE);
    biu_ack_o     = beat_ok;
    biu_d_ack_o   = beat_ok && we_q;
    biu_err_o     = (state_q == ST_ERR) || beat_err;
    biu_adro_o    = cur_adr;
    biu_tago_o    = tag_q;
    biu_q_o       = rd_ack ? ram_q : hold_q;
    if (rst_i) begin
      biu_stb_ack_o = 1'b0;
      biu_ack_o     = 1'b0;
      biu_d_ack_o   = 1'b0;
      biu_err_o     = 1'b0;
      biu_adro_o    = '0;
      biu_tago_o    = '0;
      biu_q_o       = '0;
    end
  end

  // lock/prot are accepted without effect; offset high bits select nothing
  assign unused_ok = ^{biu_lock_i, biu_prot_i, be8, rd_off, wr_off};

endmodule

// File: tb/tb_riscv_biu_tcm_responder.sv
// Self-checking bench: two responders (BASE 0 / no waits, BASE 0x100 / 2 waits)
// compared beat by beat against a transaction-level model of the BIU rules.
module tb_riscv_biu_tcm_responder;
  import biu_constants_pkg::*;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst     [2];
  logic        stb     [2];
  logic        stb_ack [2];
  logic        d_ack   [2];
  logic [31:0] adri    [2];
  logic [31:0] adro    [2];
  biu_size_t   sz      [2];
  biu_type_t   ty      [2];
  logic        we      [2];
  logic        lock    [2];
  biu_prot_t   prot    [2];
  logic [31:0] dd      [2];
  logic [31:0] q       [2];
  logic        ack     [2];
  logic        err     [2];
  logic [1:0]  tagi    [2];
  logic [1:0]  tago    [2];

  logic [31:0] mdl [2][DEPTH];
  int          checks, passed, fails;
  logic [31:0] last_q, fixd;
  bit          use_fix;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    riscv_biu_tcm_responder #(
      .XLEN(32), .PLEN(32), .BIUTAG_SIZE(2), .DEPTH(DEPTH),
      .BASE((g == 0) ? 64'd0 : 64'd256), .WAIT_STATES((g == 0) ? 0 : 2)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .biu_stb_i(stb[g]), .biu_stb_ack_o(stb_ack[g]),
      .biu_d_ack_o(d_ack[g]), .biu_adri_i(adri[g]), .biu_adro_o(adro[g]),
      .biu_size_i(sz[g]), .biu_type_i(ty[g]), .biu_we_i(we[g]), .biu_lock_i(lock[g]),
      .biu_prot_i(prot[g]), .biu_d_i(dd[g]), .biu_q_o(q[g]), .biu_ack_o(ack[g]),
      .biu_err_o(err[g]), .biu_tagi_i(tagi[g]), .biu_tago_o(tago[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int dv, input string tag);
    chk({tag, "_stb_ack"}, stb_ack[dv], 0);
    chk({tag, "_ack"},     ack[dv],     0);
    chk({tag, "_err"},     err[dv],     0);
    chk({tag, "_d_ack"},   d_ack[dv],   0);
    chk({tag, "_adro"},    adro[dv],    0);
    chk({tag, "_tago"},    tago[dv],    0);
    chk({tag, "_q"},       q[dv],       0);
  endtask

  // One transaction: expected beat addresses, timing and data come from the model
  task automatic xfer(input int dv, input logic [31:0] adr, input biu_size_t s,
                      input biu_type_t t, input bit w, input logic [1:0] tag, input int rst_at);
    int          ws, n, nev, c, k, g, idx, off, blk;
    longint      base, top, la, st;
    longint      ba [16];
    bit          berr [16];
    logic [31:0] wd [16];
    bit          e0, ev;
    ws   = (dv == 0) ? 0 : 2;
    base = (dv == 0) ? 0 : 256;
    top  = base + DEPTH * 4;
    la   = adr;
    n    = (t == SINGLE) ? 1 : (t == WRAP4 || t == INCR4) ? 4
         : (t == WRAP8 || t == INCR8) ? 8 : (t == WRAP16 || t == INCR16) ? 16 : 0;
    e0   = (la < base) || (la >= top) || (la % (1 << int'(s)) != 0) || (s > WORD)
         || (t != SINGLE && s != WORD) || (t == INCR);
    nev  = 0;
    if (!e0) begin
      for (int i = 0; i < n; i++) begin
        if (t == WRAP4 || t == WRAP8 || t == WRAP16) begin
          blk   = n * 4;
          st    = la - (la % blk);
          ba[i] = st + ((la - st + 4 * i) % blk);
        end else ba[i] = la + 4 * i;
        berr[i] = (ba[i] >= top);
        nev++;
        if (berr[i]) break;
      end
    end
    for (int i = 0; i < 16; i++) wd[i] = $urandom;
    if (use_fix) wd[0] = fixd;

    g = 0;
    @(negedge clk);
    while (!stb_ack[dv] && g < 100) begin @(negedge clk); g++; end
    chk("idle_stb_ack", stb_ack[dv], 1);
    stb[dv] = 1'b1; adri[dv] = adr; sz[dv] = s; ty[dv] = t; we[dv] = w;
    tagi[dv] = tag; lock[dv] = 1'($urandom); prot[dv] = 3'($urandom); dd[dv] = wd[0];
    @(negedge clk);
    stb[dv] = 1'b0;
    if (e0) begin
      chk("acc_err",     err[dv],     1);
      chk("acc_err_ack", ack[dv],     0);
      chk("acc_err_dak", d_ack[dv],   0);
      chk("acc_err_adr", adro[dv],    adr);
      chk("acc_err_tag", tago[dv],    tag);
      chk("acc_err_stb", stb_ack[dv], 0);
      @(negedge clk);
      chk("err_one_cyc", err[dv],     0);
      chk("err_to_idle", stb_ack[dv], 1);
      return;
    end
    k = 0; c = 1;
    while (k < nev && c < 200) begin
      ev = (c == 1 + ws + k * (ws + 1));
      dd[dv] = wd[k];
      chk("beat_ack",   ack[dv],     ev && !berr[k]);
      chk("beat_err",   err[dv],     ev && berr[k]);
      chk("beat_d_ack", d_ack[dv],   ev && w && !berr[k]);
      chk("busy_stb",   stb_ack[dv], 0);
      if (ev) begin
        chk("beat_adro", adro[dv], ba[k]);
        chk("beat_tago", tago[dv], tag);
        if (!berr[k]) begin
          idx = int'((ba[k] - base) / 4);
          if (w) begin
            off = (t == SINGLE) ? int'(la % 4) : 0;
            for (int b = off; b < off + (1 << int'(s)); b++)
              mdl[dv][idx][8*b +: 8] = wd[k][8*b +: 8];
          end else begin
            chk("beat_q", q[dv], mdl[dv][idx]);
            last_q = q[dv];
          end
        end
        k++;
        if (rst_at == k - 1) begin
          rst[dv] = 1'b1;
          @(negedge clk);
          chk_quiet(dv, "rst_mid");
          @(negedge clk);
          chk_quiet(dv, "rst_idle");
          rst[dv] = 1'b0;
          @(negedge clk);
          chk("rst_rel_stb", stb_ack[dv], 1);
          for (int i = 0; i < 4; i++) begin
            chk("rst_no_ack", ack[dv], 0);
            @(negedge clk);
          end
          return;
        end
      end
      c++;
      @(negedge clk);
    end
    if (k < nev) chk("beat_timeout", k, nev);
    chk("end_to_idle", stb_ack[dv], 1);
    chk("end_no_ack",  ack[dv],     0);
    if (!w && !berr[nev-1]) chk("q_hold", q[dv], last_q);
  endtask

  initial begin
    checks = 0; passed = 0; fails = 0; use_fix = 0; fixd = '0; last_q = '0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; stb[i] = 1'b0; adri[i] = '0; sz[i] = WORD; ty[i] = SINGLE;
      we[i] = 1'b0; lock[i] = 1'b0; prot[i] = '0; dd[i] = '0; tagi[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_quiet(0, "reset0");
    chk_quiet(1, "reset1");
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_stb",  stb_ack[i], 1);
      chk("post_rst_adro", adro[i],    0);
      chk("post_rst_tago", tago[i],    0);
    end

    // Preload both RAMs so every later read has a known expected word
    for (int dv = 0; dv < 2; dv++)
      for (int b = 0; b < 4; b++)
        xfer(dv, 32'((dv == 0 ? 0 : 256) + b * 64), WORD, INCR16, 1, 2'(b), -1);

    use_fix = 1;
    fixd = 32'hDEADBEEF; xfer(0, 32'h10, WORD, SINGLE, 1, 2'd1, -1);
    xfer(0, 32'h10, WORD, SINGLE, 0, 2'd1, -1);
    chk("rd_deadbeef", last_q, 32'hDEADBEEF);
    fixd = 32'h11223344; xfer(0, 32'h20, WORD, SINGLE, 1, 2'd0, -1);
    fixd = 32'h00AA0000; xfer(0, 32'h22, BYTE, SINGLE, 1, 2'd3, -1);
    xfer(0, 32'h20, WORD, SINGLE, 0, 2'd0, -1);
    chk("byte_lane2", last_q, 32'h11AA3344);
    use_fix = 0;

    xfer(0, 32'h08, WORD, WRAP4, 0, 2'd2, -1);
    xfer(1, 32'h140, WORD, INCR8, 1, 2'd1, -1);
    xfer(1, 32'h144, WORD, WRAP8, 0, 2'd3, -1);
    xfer(0, 32'h100, WORD, SINGLE, 0, 2'd1, -1);
    xfer(0, 32'h3, HWORD, SINGLE, 0, 2'd2, -1);
    xfer(0, 32'h0, WORD, INCR, 0, 2'd0, -1);
    xfer(0, 32'h4, BYTE, INCR4, 0, 2'd0, -1);
    xfer(1, 32'h80, WORD, SINGLE, 1, 2'd1, -1);
    xfer(0, 32'hF0, WORD, INCR8, 1, 2'd3, -1);
    xfer(1, 32'h1F8, WORD, INCR4, 0, 2'd2, -1);
    xfer(0, 32'h10, WORD, SINGLE, 0, 2'd1, -1);

    xfer(0, 32'h40, WORD, INCR4, 0, 2'd1, 1);
    xfer(0, 32'h40, WORD, INCR4, 0, 2'd2, -1);

    for (int r = 0; r < 60; r++) begin
      int          dv;
      biu_size_t   s;
      biu_type_t   t;
      logic [31:0] a;
      dv = int'($urandom_range(0, 1));
      t  = ($urandom_range(0, 2) == 0) ? SINGLE : biu_type_t'(3'($urandom_range(0, 7)));
      s  = biu_size_t'(3'($urandom_range(0, 3)));
      if (t != SINGLE && $urandom_range(0, 4) != 0) s = WORD;
      a  = 32'((dv == 0 ? 0 : 256) + $urandom_range(0, DEPTH * 4 + 31));
      if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << int'(s)) - 32'd1);
      xfer(dv, a, s, t, 1'($urandom), 2'($urandom), -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
